// File: rtl/cw_clock_pkg.sv
// cw_clock_pkg: shared time constants, key codes and repeat FSM states for the digital clock
package cw_clock_pkg;
  localparam int SEC_PER_DAY = 86400;
  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN = 60;
  typedef enum logic [1:0] {KEY_NONE = 2'b00, KEY_HOUR = 2'b01, KEY_MIN = 2'b10, KEY_CLR = 2'b11} key_t;
  typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;
endpackage

// File: rtl/cw_key_repeat.sv
// cw_key_repeat: synchronizes the adjust button and emits hold-to-repeat step pulses in set mode
module cw_key_repeat
  import cw_clock_pkg::*;
#(
  parameter int RPT_DLY = 5,
  parameter int RPT_PER = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  input  logic btn,
  output logic step
);
  localparam logic [7:0] DLY_END = 8'(RPT_DLY - 1);
  localparam logic [7:0] PER_END = 8'(RPT_PER - 1);
  logic s1, btn_s;
  logic [7:0] rcnt, rcnt_n;
  rpt_state_t st, nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      btn_s <= 1'b0;
      st <= IDLE;
      rcnt <= '0;
    end else begin
      s1 <= btn;
      btn_s <= s1;
      st <= nxt;
      rcnt <= rcnt_n;
    end
  // step is Mealy so the count updates on the edge right after btn_s is seen
  always_comb begin
    nxt = st;
    rcnt_n = rcnt;
    step = 1'b0;
    if (!sw) begin
      nxt = IDLE;
      rcnt_n = '0;
    end else
      case (st)
        IDLE: if (btn_s) begin
          step = 1'b1;
          rcnt_n = '0;
          nxt = HOLD;
        end
        HOLD: if (!btn_s) nxt = IDLE;
          else if (rcnt == DLY_END) begin
            step = 1'b1;
            rcnt_n = '0;
            nxt = RPT;
          end else rcnt_n = rcnt + 8'd1;
        RPT: if (!btn_s) nxt = IDLE;
          else if (rcnt == PER_END) begin
            step = 1'b1;
            rcnt_n = '0;
          end else rcnt_n = rcnt + 8'd1;
        default: nxt = IDLE;
      endcase
  end
endmodule

// File: rtl/cw_timekeeper.sv
// cw_timekeeper: seconds-of-day counter with 1 Hz prescaler and button-driven set mode
module cw_timekeeper
  import cw_clock_pkg::*;
#(
  parameter int DIV = 10,
  parameter int SEC_MAX = 86399,
  parameter int RPT_DLY = 5,
  parameter int RPT_PER = 2
) (
  input  logic        Clk_10hz,
  input  logic        n_Global_Rst,
  input  logic        Sw,
  input  logic [1:0]  Key,
  input  logic        Adj_Btn,
  output logic [16:0] Clock_Sec_Cnt,
  output logic        Sec_Tick,
  output logic        Set_Active
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_END = PW'(DIV - 1);
  localparam logic [17:0] DAY = 18'(SEC_MAX + 1);
  logic [PW-1:0] pre;
  logic [5:0] sec_of_min;
  logic step, tick;
  logic [17:0] base, sum, adj;
  key_t k;
  cw_key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_rpt (
    .clk(Clk_10hz),
    .rst_n(n_Global_Rst),
    .sw(Sw),
    .btn(Adj_Btn),
    .step(step)
  );
  always_comb begin
    k = key_t'(Key);
    tick = !Sw && pre == PRE_END;
    base = {1'b0, Clock_Sec_Cnt};
    sum = k == KEY_CLR ? base - {12'd0, sec_of_min}
        : base + (k == KEY_HOUR ? 18'(SEC_PER_HOUR) : k == KEY_MIN ? 18'(SEC_PER_MIN) : 18'd0);
    adj = sum >= DAY ? sum - DAY : sum;
  end
  // set mode holds the prescaler at 0, so steps and ticks never coincide
  always_ff @(posedge Clk_10hz or negedge n_Global_Rst)
    if (!n_Global_Rst) begin
      Clock_Sec_Cnt <= '0;
      Sec_Tick <= 1'b0;
      Set_Active <= 1'b0;
      pre <= '0;
      sec_of_min <= '0;
    end else begin
      Set_Active <= Sw;
      Sec_Tick <= tick;
      pre <= (Sw || tick) ? '0 : pre + 1'b1;
      if (step) begin
        Clock_Sec_Cnt <= adj[16:0];
        if (k == KEY_CLR) sec_of_min <= '0;
      end else if (tick) begin
        Clock_Sec_Cnt <= Clock_Sec_Cnt == 17'(SEC_MAX) ? '0 : Clock_Sec_Cnt + 17'd1;
        sec_of_min <= sec_of_min == 6'd59 ? '0 : sec_of_min + 6'd1;
      end
    end
endmodule

// File: tb/tb_cw_timekeeper.sv
// tb_cw_timekeeper: random and directed stimulus checked against a behavioural clock model
module tb_cw_timekeeper;
  logic clk = 1'b0, rst_n = 1'b0, sw = 1'b0, btn = 1'b0;
  logic [1:0] key = 2'b00;
  logic [16:0] cnt;
  logic tick, set_act;
  int errs = 0, n_chk = 0;
  int m_cnt, m_run, m_h, m_s1, m_s2, m_tick, m_set;
  cw_timekeeper dut (
    .Clk_10hz(clk),
    .n_Global_Rst(rst_n),
    .Sw(sw),
    .Key(key),
    .Adj_Btn(btn),
    .Clock_Sec_Cnt(cnt),
    .Sec_Tick(tick),
    .Set_Active(set_act)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int n);
    btn = 1'b1;
    cyc(n);
    btn = 1'b0;
    cyc(5);
  endtask
  // model: count of consecutive synchronized-high set-mode cycles decides steps
  initial begin
    bit st, tk;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cnt = 0; m_run = 0; m_h = 0; m_s1 = 0; m_s2 = 0; m_tick = 0; m_set = 0;
      end else begin
        st = sw && m_s2 != 0 && (m_h == 0 || (m_h >= 5 && (m_h - 5) % 2 == 0));
        m_h = (sw && m_s2 != 0) ? m_h + 1 : 0;
        tk = !sw && m_run % 10 == 9;
        m_run = sw ? 0 : m_run + 1;
        if (st) begin
          if (key == 2'b01) m_cnt = (m_cnt + 3600) % 86400;
          else if (key == 2'b10) m_cnt = (m_cnt + 60) % 86400;
          else if (key == 2'b11) m_cnt = m_cnt - m_cnt % 60;
        end else if (tk) m_cnt = (m_cnt + 1) % 86400;
        m_tick = tk;
        m_set = sw;
        m_s2 = m_s1;
        m_s1 = btn;
      end
      #1;
      chk("cnt", cnt, m_cnt);
      chk("tick", tick, m_tick);
      chk("set_active", set_act, m_set);
      chk("sec_of_min", dut.sec_of_min, m_cnt % 60);
    end
  end
  initial begin
    cyc(2);
    chk("rst_cnt", cnt, 0);
    chk("rst_tick", tick, 0);
    rst_n = 1'b1;
    cyc(10);
    chk("first_tick", cnt, 1);
    cyc(590);
    chk("min_60", cnt, 60);
    cyc(590);
    chk("run_119", cnt, 119);
    sw = 1'b1;
    key = 2'b01;
    repeat (23) press(2);
    key = 2'b10;
    repeat (58) press(2);
    chk("preload", cnt, 86399);
    sw = 1'b0;
    cyc(10);
    chk("day_wrap", cnt, 0);
    chk("wrap_som", dut.sec_of_min, 0);
    sw = 1'b1;
    key = 2'b01;
    repeat (23) press(2);
    key = 2'b10;
    repeat (30) press(2);
    chk("at_2330", cnt, 84600);
    key = 2'b01;
    press(2);
    chk("hour_wrap", cnt, 1800);
    repeat (23) press(2);
    key = 2'b10;
    repeat (29) press(2);
    chk("at_86340", cnt, 86340);
    press(2);
    chk("min_wrap", cnt, 0);
    press(12);
    chk("hold_repeat", cnt, 300);
    cyc(10);
    chk("hold_release", cnt, 300);
    rst_n = 1'b0;
    sw = 1'b0;
    cyc(1);
    chk("rst2", cnt, 0);
    rst_n = 1'b1;
    cyc(1250);
    chk("run_125", cnt, 125);
    sw = 1'b1;
    key = 2'b11;
    press(2);
    chk("clr_sec", cnt, 120);
    press(2);
    chk("clr_again", cnt, 120);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    key = 2'b01;
    press(2);
    chk("at_3600", cnt, 3600);
    btn = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("async_rst", cnt, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_wait", cnt, 0);
    cyc(1);
    chk("post_rst_step", cnt, 3600);
    cyc(4);
    chk("no_carry", cnt, 3600);
    cyc(1);
    chk("fresh_repeat", cnt, 7200);
    btn = 1'b0;
    cyc(5);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom % 600) != 0;
      if ($urandom % 60 == 0) sw = ~sw;
      if ($urandom % 7 == 0) key = 2'($urandom);
      if ($urandom % 6 == 0) btn = ~btn;
    end
    rst_n = 1'b1;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule

// File: doc/cw_timekeeper.md
Name: cw_timekeeper

Overview:
- Time-of-day seconds counter for the digital clock.
- Generates the 17-bit seconds-of-day count consumed by the alarm comparator and the display path.
- Divides Clk_10hz down to a 1 Hz advance.
- Provides a set mode in which hour, minute or seconds-clear adjustments are applied from a single adjust button with hold-to-repeat.

Parameters:
- DIV, 10, Clk_10hz cycles per second.
- SEC_MAX, 86399, last valid seconds-of-day value.
- RPT_DLY, 5, synchronized-high cycles before auto-repeat starts.
- RPT_PER, 2, cycles between auto-repeat steps.

Ports:
- Clk_10hz  in  1  system clock (10 Hz).
- n_Global_Rst  in  1  asynchronous active-low reset.
- Sw  in  1  set mode: 1 = set (time frozen), 0 = run. Quasi-static.
- Key  in  2  adjust select: 01 = +1 hour, 10 = +1 minute, 11 = clear seconds-of-minute, 00 = none. Quasi-static.
- Adj_Btn  in  1  adjust button, asynchronous to logic.
- Clock_Sec_Cnt  out  17  seconds of day, 0..SEC_MAX.
- Sec_Tick  out  1  one-cycle pulse on each run-mode advance.
- Set_Active  out  1  registered copy of Sw.

Behaviour:
- Reset (n_Global_Rst low, asynchronous): Clock_Sec_Cnt = 0, Sec_Tick = 0, Set_Active = 0, prescaler = 0, sec_of_min = 0, repeat FSM = IDLE, sync flops = 0.
- Run mode (Sw = 0):
  - Prescaler counts 0..DIV-1.
  - On the edge where prescaler = DIV-1: prescaler goes to 0, Clock_Sec_Cnt increments, Sec_Tick = 1 for that one cycle.
  - Wrap: SEC_MAX + 1 gives 0.
  - sec_of_min (0..59) increments alongside Clock_Sec_Cnt and wraps 59 to 0.
- Set mode (Sw = 1):
  - Prescaler is held at 0 and no ticks occur.
  - Changes to Clock_Sec_Cnt come only from adjust steps.
- Leaving set mode: prescaler restarts from 0, so the first tick is DIV cycles after Sw is sampled low. Adjust and tick are therefore mutually exclusive; no simultaneous-event case exists.
- Adjust step arithmetic, performed modulo SEC_MAX + 1 with an 18-bit intermediate; sum > SEC_MAX gives sum − (SEC_MAX + 1):
  - Key = 01: add 3600; sec_of_min unchanged.
  - Key = 10: add 60; sec_of_min unchanged.
  - Key = 11: subtract sec_of_min; sec_of_min becomes 0.
  - Key = 00: step is a no-op, but the FSM still runs.
- Adj_Btn synchronization: 2-flop synchronizer producing btn_s. A step is registered on the edge after the FSM decides, so Clock_Sec_Cnt changes on the 3rd rising edge after Adj_Btn is first sampled high.
- Repeat FSM (active only while Sw = 1; if Sw = 0 it is forced to IDLE and takes no step):
  - IDLE: on btn_s = 1, take a step, clear rcnt, go to HOLD.
  - HOLD: if btn_s = 0, go to IDLE. Otherwise rcnt increments; when rcnt reaches RPT_DLY − 1, take a step, clear rcnt, go to RPT.
  - RPT: if btn_s = 0, go to IDLE. Otherwise step each time rcnt reaches RPT_PER − 1, then clear rcnt.
  - Resulting step cycles, relative to the first synchronized-high cycle: 0, RPT_DLY, RPT_DLY + RPT_PER, and so on.
- Sw falling during HOLD or RPT: FSM goes to IDLE immediately and no further steps are taken.
- Key changes while held: each step uses the Key value on the cycle of that step.
- Reset asserted mid-operation: all state cleared asynchronously. After release, counting resumes from 0 with the full DIV-cycle first tick.
- Clock_Sec_Cnt is always registered and never exceeds SEC_MAX.

Decomposition:
- Shared package cw_clock_pkg:
  - SEC_PER_DAY = 86400, SEC_PER_HOUR = 3600, SEC_PER_MIN = 60.
  - Key codes KEY_NONE, KEY_HOUR, KEY_MIN, KEY_CLR.
  - Repeat FSM state encoding (IDLE, HOLD, RPT).
- One sub-module: cw_key_repeat.
  - Contains the synchronizer, the repeat FSM and rcnt.
  - Outputs a one-cycle Step pulse, gated by Sw.
- Arithmetic and the prescaler stay in the top module.

Test Plan:
- Reset release in run mode, 10 cycles → Clock_Sec_Cnt = 1 and Sec_Tick high exactly on the 10th edge; after 600 cycles → 60.
- Preload to 86399 via set adjusts, then run 10 cycles → Clock_Sec_Cnt = 0, Sec_Tick pulses once, sec_of_min = 0.
- Set mode at 84600 (23:30:00), Key = 01, one short press (2 synchronized cycles) → 1800. At 86340, Key = 10, one press → 0.
- Set mode at 0, Key = 10, btn_s held 12 cycles → steps at cycles 0, 5, 7, 9, 11 → Clock_Sec_Cnt = 300. Release → no further change.
- Run to 125 (00:02:05), then Sw = 1, Key = 11, press → 120. A second press → 120 unchanged.
- n_Global_Rst pulsed low mid-hold at 3600 → immediate 0 and FSM IDLE. A held button after release gives its first step only 3 edges after release, with no repeat carry-over.
